// File: rtl/ise_dispatch_pkg.sv
// ise_dispatch_pkg
//   Shared definitions for the bit-manipulation ISE port, used by the
//   dispatcher and by the ISE responder:
//     - FN_* function codes 32..43
//     - RISC-V opcode / funct7 / funct3 constants for the Zbkb subset
//     - dispatcher FSM state encoding (IDLE=0, ISSUE=1, RESP=2)
package ise_dispatch_pkg;

  localparam logic [5:0] FN_ROR   = 6'd32;
  localparam logic [5:0] FN_ROL   = 6'd33;
  localparam logic [5:0] FN_RORI  = 6'd34;
  localparam logic [5:0] FN_ANDN  = 6'd35;
  localparam logic [5:0] FN_ORN   = 6'd36;
  localparam logic [5:0] FN_XNOR  = 6'd37;
  localparam logic [5:0] FN_PACK  = 6'd38;
  localparam logic [5:0] FN_PACKH = 6'd39;
  localparam logic [5:0] FN_RORW  = 6'd40;
  localparam logic [5:0] FN_ROLW  = 6'd41;
  localparam logic [5:0] FN_RORIW = 6'd42;
  localparam logic [5:0] FN_PACKW = 6'd43;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [6:0] F7_ROT  = 7'b0110000;
  localparam logic [6:0] F7_NEG  = 7'b0100000;
  localparam logic [6:0] F7_PACK = 7'b0000100;

  // RORI carries a 6-bit shamt, so only insn[31:26] is fixed
  localparam logic [5:0] F6_RORI = 6'b011000;

  localparam logic [2:0] F3_ROR   = 3'b101;
  localparam logic [2:0] F3_ROL   = 3'b001;
  localparam logic [2:0] F3_ANDN  = 3'b111;
  localparam logic [2:0] F3_ORN   = 3'b110;
  localparam logic [2:0] F3_XNOR  = 3'b100;
  localparam logic [2:0] F3_PACK  = 3'b100;
  localparam logic [2:0] F3_PACKH = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/ise_dispatch_if.sv
// ise_dispatch_if
//   Bundles the three channels around the dispatcher:
//     req_*  : instruction request from execute (valid/ready)
//     rsp_*  : writeback to the core (valid/ready)
//     ise_*  : function-code request to the ISE and its result
//   Modports:
//     slave  : the dispatcher's view
//     master : the environment's view (core + ISE)
interface ise_dispatch_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [63:0] rsp_data;
  logic        rsp_illegal;
  logic        rsp_timeout;

  logic [5:0]  ise_fn;
  logic [63:0] ise_in1;
  logic [63:0] ise_in2;
  logic        ise_val;
  logic        ise_oval;
  logic [63:0] ise_out;

  modport slave (
    input  req_valid, req_insn, req_rs1, req_rs2, rsp_ready, ise_oval, ise_out,
    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_illegal, rsp_timeout,
           ise_fn, ise_in1, ise_in2, ise_val
  );

  modport master (
    output req_valid, req_insn, req_rs1, req_rs2, rsp_ready, ise_oval, ise_out,
    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_illegal, rsp_timeout,
           ise_fn, ise_in1, ise_in2, ise_val
  );

endinterface

// File: rtl/ise_dispatch_decode.sv
// ise_dispatch_decode
//   Combinational Zbkb decoder: raw instruction -> ISE function code.
//   Ports:
//     i_insn    : raw 32-bit instruction
//     o_fn      : ISE function code (0 when illegal)
//     o_legal   : instruction is one of the twelve ISE operations
//     o_imm_sel : operand 2 is the immediate shamt rather than rs2
//     o_imm     : zero-extended shamt (6 bits for RORI, 5 for RORIW)
module ise_dispatch_decode
  import ise_dispatch_pkg::*;
(
  input  logic [31:0] i_insn,
  output logic [5:0]  o_fn,
  output logic        o_legal,
  output logic        o_imm_sel,
  output logic [5:0]  o_imm
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_unused;

  assign w_opc = i_insn[6:0];
  assign w_f7  = i_insn[31:25];
  assign w_f3  = i_insn[14:12];

  // register-number fields are not part of the function decode
  assign w_unused = ^{i_insn[19:15], i_insn[11:7]};

  always_comb begin
    o_fn      = '0;
    o_legal   = 1'b0;
    o_imm_sel = 1'b0;
    o_imm     = '0;
    case (w_opc)
      OPC_OP: begin
        o_legal = 1'b1;
        case ({w_f7, w_f3})
          {F7_ROT,  F3_ROR}:   o_fn = FN_ROR;
          {F7_ROT,  F3_ROL}:   o_fn = FN_ROL;
          {F7_NEG,  F3_ANDN}:  o_fn = FN_ANDN;
          {F7_NEG,  F3_ORN}:   o_fn = FN_ORN;
          {F7_NEG,  F3_XNOR}:  o_fn = FN_XNOR;
          {F7_PACK, F3_PACK}:  o_fn = FN_PACK;
          {F7_PACK, F3_PACKH}: o_fn = FN_PACKH;
          default:             o_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        if (i_insn[31:26] == F6_RORI && w_f3 == F3_ROR) begin
          o_fn      = FN_RORI;
          o_legal   = 1'b1;
          o_imm_sel = 1'b1;
          o_imm     = i_insn[25:20];
        end
      end
      OPC_OP_32: begin
        o_legal = 1'b1;
        case ({w_f7, w_f3})
          {F7_ROT,  F3_ROR}:  o_fn = FN_RORW;
          {F7_ROT,  F3_ROL}:  o_fn = FN_ROLW;
          {F7_PACK, F3_PACK}: o_fn = FN_PACKW;
          default:            o_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        if (w_f7 == F7_ROT && w_f3 == F3_ROR) begin
          o_fn      = FN_RORIW;
          o_legal   = 1'b1;
          o_imm_sel = 1'b1;
          o_imm     = {1'b0, i_insn[24:20]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ise_dispatch.sv
// ise_dispatch
//   Core-side initiator for the bit-manipulation ISE port. Accepts one Zbkb
//   instruction with rs1/rs2, issues it to the ISE as a function code, and
//   returns the result with rd on a writeback channel. One op in flight.
//   Ports:
//     ise_clk : clock
//     ise_rst : asynchronous active-high reset
//     bus     : ise_dispatch_if.slave (req_*, rsp_*, ise_* channels)
//   Parameter:
//     TIMEOUT_CYC : ISSUE cycles without ise_oval before abort
//   Build option:
//     ISE_TIMEOUT_EN : enables the ISSUE watchdog; when undefined ISSUE waits
//                      indefinitely and rsp_timeout stays 0.
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | ise_val high, operands held, waiting for ise_oval
//   RESP  | rsp_valid high, result held until rsp_ready
module ise_dispatch
  import ise_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input logic           ise_clk,
  input logic           ise_rst,
  ise_dispatch_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_req_ready;
  logic        w_ise_val;
  logic        w_rsp_valid;

  logic [5:0]  w_dec_fn;
  logic        w_dec_legal;
  logic        w_dec_imm_sel;
  logic [5:0]  w_dec_imm;

  logic        w_accept;
  logic        w_take;
  logic        w_to_hit;

  logic [5:0]  r_fn;
  logic [63:0] r_in1;
  logic [63:0] r_in2;
  logic [4:0]  r_rd;
  logic [63:0] r_data;
  logic        r_illegal;
  logic        r_timeout;

  ise_dispatch_decode u_decode (
    .i_insn    (bus.req_insn),
    .o_fn      (w_dec_fn),
    .o_legal   (w_dec_legal),
    .o_imm_sel (w_dec_imm_sel),
    .o_imm     (w_dec_imm)
  );

  assign w_accept = bus.req_valid && w_req_ready;
  // ise_oval only counts while we are actually requesting
  assign w_take   = w_ise_val && bus.ise_oval;

`ifdef ISE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_ise_val && !bus.ise_oval) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // a result arriving on the terminal cycle beats the timeout
  assign w_to_hit = w_ise_val && !bus.ise_oval &&
                    (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC == 0);
  assign w_to_hit     = 1'b0;
`endif

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_ise_val   = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_nxt = w_dec_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        w_ise_val = 1'b1;
        if (bus.ise_oval || w_to_hit) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      r_fn      <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_rd      <= '0;
      r_data    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fn      <= w_dec_fn;
        r_in1     <= bus.req_rs1;
        r_in2     <= w_dec_imm_sel ? {58'd0, w_dec_imm} : bus.req_rs2;
        r_rd      <= bus.req_insn[11:7];
        r_data    <= '0;
        r_illegal <= !w_dec_legal;
        r_timeout <= 1'b0;
      end
      if (w_take) begin
        r_data <= bus.ise_out;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_rd      = r_rd;
  assign bus.rsp_data    = r_data;
  assign bus.rsp_illegal = r_illegal;
  assign bus.rsp_timeout = r_timeout;
  assign bus.ise_fn      = r_fn;
  assign bus.ise_in1     = r_in1;
  assign bus.ise_in2     = r_in2;
  assign bus.ise_val     = w_ise_val;

endmodule

// File: tb/tb_ise_dispatch.sv
// tb_ise_dispatch
//   Directed bench for ise_dispatch. The bench plays both the core and a
//   combinational ISE responder (ise_stall holds ise_oval low).
//   Timeout vectors are only built when ISE_TIMEOUT_EN is defined.
module tb_ise_dispatch;

  logic ise_clk;
  logic ise_rst;
  logic ise_stall;

  int n_chk  = 0;
  int n_pass = 0;

  ise_dispatch_if bus ();

  ise_dispatch #(.TIMEOUT_CYC(16)) u_dut (
    .ise_clk (ise_clk),
    .ise_rst (ise_rst),
    .bus     (bus)
  );

  initial begin
    ise_clk = 1'b0;
    forever #5 ise_clk = ~ise_clk;
  end

  function automatic logic [63:0] ise_model(input logic [5:0] fn,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] t;
    logic [63:0]  t32;
    logic [63:0]  r;
    r = '0;
    case (fn)
      6'd32, 6'd34: begin t = {a, a} >> b[5:0]; r = t[63:0]; end
      6'd33:        begin t = {a, a} << b[5:0]; r = t[127:64]; end
      6'd35:        r = a & ~b;
      6'd36:        r = a | ~b;
      6'd37:        r = ~(a ^ b);
      6'd38:        r = {b[31:0], a[31:0]};
      6'd39:        r = {48'd0, b[7:0], a[7:0]};
      6'd40, 6'd42: begin t32 = {a[31:0], a[31:0]} >> b[4:0]; r = {32'd0, t32[31:0]}; end
      6'd41:        begin t32 = {a[31:0], a[31:0]} << b[4:0]; r = {32'd0, t32[63:32]}; end
      6'd43:        r = {32'd0, b[15:0], a[15:0]};
      default:      r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    bus.ise_oval = bus.ise_val && !ise_stall;
    bus.ise_out  = ise_model(bus.ise_fn, bus.ise_in1, bus.ise_in2);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    int          nval;
    int          lat;
    logic [5:0]  fn;
    logic [63:0] in2;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        ill;
    logic        to;
    logic        stable;
    logic        rdy_after;
  } res_t;

  task automatic send(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2);
    int k;
    k = 0;
    @(negedge ise_clk);
    while (!bus.req_ready && k < 50) begin
      @(negedge ise_clk);
      k++;
    end
    bus.req_insn  = insn;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_valid = 1'b1;
    @(posedge ise_clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] insn, input logic [63:0] rs1,
                        input logic [63:0] rs2, input int hold, output res_t r);
    int k;
    r.nval = 0; r.lat = 0; r.fn = '0; r.in2 = '0;
    send(insn, rs1, rs2);
    k = 0;
    do begin
      @(negedge ise_clk);
      k++;
      if (bus.ise_val) begin
        r.nval++;
        r.fn  = bus.ise_fn;
        r.in2 = bus.ise_in2;
      end
    end while (!bus.rsp_valid && k < 200);
    r.lat    = k;
    r.data   = bus.rsp_data;
    r.rd     = bus.rsp_rd;
    r.ill    = bus.rsp_illegal;
    r.to     = bus.rsp_timeout;
    r.stable = bus.rsp_valid;
    for (int i = 0; i < hold; i++) begin
      @(negedge ise_clk);
      if (bus.rsp_data !== r.data || bus.rsp_rd !== r.rd || bus.rsp_illegal !== r.ill ||
          !bus.rsp_valid || bus.req_ready)
        r.stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge ise_clk);
    #1;
    bus.rsp_ready = 1'b0;
    r.rdy_after = bus.req_ready;
  endtask

  res_t r;

  initial begin
    ise_rst       = 1'b1;
    ise_stall     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_insn  = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge ise_clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_ise_val", bus.ise_val, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_flags", {bus.rsp_illegal, bus.rsp_timeout}, 0);
    chk("rst_ise_ops", bus.ise_fn | bus.ise_in1 | bus.ise_in2, 0);
    chk("rst_rsp_regs", bus.rsp_data | 64'(bus.rsp_rd), 0);
    ise_rst = 1'b0;

    // ROR x3, x1, x2 : 1 rotated right by 1
    run_op(32'h6020D1B3, 64'h1, 64'h1, 0, r);
    chk("ror_fn", r.fn, 32);
    chk("ror_val_cycles", r.nval, 1);
    chk("ror_latency", r.lat, 2);
    chk("ror_rd", r.rd, 3);
    chk("ror_data", r.data, 64'h8000_0000_0000_0000);
    chk("ror_flags", {r.ill, r.to}, 0);
    chk("ror_ready_after", r.rdy_after, 1);

    // RORIW x10, x5, 8
    run_op(32'h6082D51B, 64'h1234_5678, 64'hFFFF, 0, r);
    chk("roriw_fn", r.fn, 42);
    chk("roriw_in2", r.in2, 8);
    chk("roriw_rd", r.rd, 10);
    chk("roriw_data", r.data, 64'h0000_0000_7812_3456);

    // PACKH x7, x1, x2 with writeback back-pressure
    run_op(32'h0820F3B3, 64'hAB, 64'hCD, 5, r);
    chk("packh_fn", r.fn, 39);
    chk("packh_data", r.data, 64'hCDAB);
    chk("packh_rd", r.rd, 7);
    chk("packh_held", r.stable, 1);
    chk("packh_ready_after", r.rdy_after, 1);

    // RORI x5, x1, 36 : rs2 must be ignored
    run_op(32'h6240D293, 64'h1, 64'hDEAD, 0, r);
    chk("rori_fn", r.fn, 34);
    chk("rori_in2", r.in2, 36);
    chk("rori_data", r.data, 64'h0000_0000_1000_0000);

    // ANDN x4, x1, x2
    run_op(32'h4020F233, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 0, r);
    chk("andn_fn", r.fn, 35);
    chk("andn_data", r.data, 64'hF000_F000_F000_F000);

    // addi x0, x0, 0 : illegal
    run_op(32'h0000_0013, 64'h55, 64'h66, 2, r);
    chk("addi_illegal", r.ill, 1);
    chk("addi_data", r.data, 0);
    chk("addi_no_ise", r.nval, 0);
    chk("addi_latency", r.lat, 1);
    chk("addi_held", r.stable, 1);
    chk("addi_ready_after", r.rdy_after, 1);

    // OP with funct7=0110000 funct3=000 is not an ISE op
    run_op(32'h6000_0033, 64'h1, 64'h1, 0, r);
    chk("badf3_illegal", r.ill, 1);
    chk("badf3_no_ise", r.nval, 0);

    // legal op after an illegal one clears the flag
    run_op(32'h6020D1B3, 64'h2, 64'h1, 0, r);
    chk("ror2_illegal", r.ill, 0);
    chk("ror2_data", r.data, 64'h1);

    // reset while the ISE is stalled
    ise_stall = 1'b1;
    send(32'h6020D1B3, 64'h1, 64'h1);
    repeat (3) @(negedge ise_clk);
    chk("stall_ise_val", bus.ise_val, 1);
    chk("stall_req_ready", bus.req_ready, 0);
    #2;
    ise_rst = 1'b1;
    #1;
    chk("rst_mid_ise_val", bus.ise_val, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    @(negedge ise_clk);
    ise_rst   = 1'b0;
    ise_stall = 1'b0;
    @(negedge ise_clk);
    chk("post_rst_ready", bus.req_ready, 1);
    // XNOR x4, x1, x2
    run_op(32'h4020C233, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 0, r);
    chk("post_rst_fn", r.fn, 37);
    chk("post_rst_data", r.data, 64'h0FF0_0FF0_0FF0_0FF0);
    chk("post_rst_latency", r.lat, 2);

`ifdef ISE_TIMEOUT_EN
    ise_stall = 1'b1;
    run_op(32'h6020D1B3, 64'h1, 64'h1, 0, r);
    ise_stall = 1'b0;
    chk("to_val_cycles", r.nval, 16);
    chk("to_flag", r.to, 1);
    chk("to_data", r.data, 0);
    chk("to_latency", r.lat, 17);
    chk("to_ready_after", r.rdy_after, 1);
    run_op(32'h6020D1B3, 64'h1, 64'h1, 0, r);
    chk("to_clear_flag", r.to, 0);
    chk("to_clear_data", r.data, 64'h8000_0000_0000_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
